grid_mem_arbiter: RTL and testbench
===================================

Name: grid_mem_arbiter

Overview:
- Single-port owner of the 15x15 snake-grid cell memory.
- Clears the grid after reset, then shares the one memory port between the VGA pixel fetch path (priority, once per vga_clk pixel) and the game-logic engine (valid/ready read/write requests).
- A starvation guard bounds game latency; a pipeline tag routes 1-cycle-latency read data back to the correct requester.

Parameters:
GRID_W, 15, cells per row
GRID_H, 15, cells per column
COORD_W, 4, coordinate width
DATA_W, 2, cell code width
MAX_WAIT, 8, cycles a pending game request may be blocked before it preempts VGA

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
vga_req  in  1  VGA fetch request this cycle
vga_x  in  COORD_W  VGA cell column
vga_y  in  COORD_W  VGA cell row
vga_data  out  DATA_W  returned cell code
vga_valid  out  1  vga_data updated this cycle
game_valid  in  1  game request pending
game_ready  out  1  game request accepted this cycle
game_we  in  1  1=write, 0=read
game_x  in  COORD_W  game cell column
game_y  in  COORD_W  game cell row
game_wdata  in  DATA_W  write cell code
game_rdata  out  DATA_W  read result
game_rvalid  out  1  game_rdata valid, 1-cycle pulse
mem_x  out  COORD_W  memory column
mem_y  out  COORD_W  memory row
mem_we  out  1  memory write strobe
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid 1 cycle after address
init_done  out  1  grid cleared, arbitration live

Behaviour:
- Reset (rst=0, asynchronous): state INIT, sweep counters 0, wait_cnt 0, tag NONE.
- Reset values: all outputs 0; game_ready 0; init_done 0.
- Reset mid-operation: any in-flight read is dropped and no rvalid is issued.
- INIT state:
  - Drives mem_we=1, mem_wdata=00, x 0..14 inner loop, y 0..14 outer; one cell per cycle, 225 cycles.
  - vga_req and game_valid are ignored; game_ready=0, vga_valid=0.
  - After cell (14,14): go to RUN; init_done=1 from the next cycle and stays 1.
- RUN grant, evaluated every cycle:
  - If vga_req=1 and wait_cnt<MAX_WAIT: grant VGA.
  - Else if game_valid=1: grant game.
  - Else: idle, mem_we=0, mem_x/mem_y=0.
- Memory port muxing: mem_x/mem_y/mem_we/mem_wdata are a combinational mux of the granted requester. mem_we is asserted only for a game write.
- Game handshake:
  - game_ready is combinational and equals the game grant.
  - A transfer occurs when game_valid & game_ready.
  - Requester holds game_we/x/y/wdata stable while valid and not ready.
  - game_valid may drop only after a transfer.
- wait_cnt:
  - Increments each cycle game_valid=1 & game_ready=0, saturating at MAX_WAIT.
  - Clears on a transfer or when game_valid=0.
- Preemption: when wait_cnt==MAX_WAIT and vga_req=1, game wins. Next cycle vga_valid=0 and vga_data holds its previous value (VGA repeats the last pixel).
- Read return:
  - A 1-bit-plus-valid tag register records the owner of each read.
  - The cycle after a VGA grant: vga_valid=1, vga_data<=mem_rdata.
  - The cycle after a game read transfer: game_rvalid=1, game_rdata<=mem_rdata.
  - Game writes produce no rvalid.
  - game_rdata holds between pulses.
- Out-of-range coordinates (x>=GRID_W or y>=GRID_H):
  - Write is suppressed (mem_we=0) but the transfer still completes.
  - Reads return 2'b11 (CELL_INVALID) with normal latency; memory data is ignored.
  - Applies to both requesters.
- Back-to-back write then read of the same cell: the read in the following cycle returns the written value. The arbiter adds no bypass; the memory writes at the clock edge.
- Latency: VGA read 1 cycle when granted. Worst-case game acceptance MAX_WAIT+1 cycles after game_valid rises in RUN.

Decomposition:
- Package grid_pkg holds:
  - Cell codes: CELL_WORLD=2'b00, CELL_FOOD=2'b01, CELL_SNAKE=2'b10, CELL_INVALID=2'b11.
  - GRID_W, GRID_H, COORD_W.
  - Owner tag constants OWN_NONE, OWN_VGA, OWN_GAME.
  - State constants ST_INIT, ST_RUN.
- One sub-module: grid_clear_sweeper.
  - Generates the x/y sweep and a done pulse.
  - Instantiated only by the INIT path.

Test Plan:
- Reset release, no requests: exactly 225 writes of 00 covering (0,0)..(14,14), then init_done=1; vga_valid and game_ready stay 0 throughout INIT.
- RUN, game write (3,4)=10, then game read (3,4): game_ready=1 immediately; game_rvalid pulses 1 cycle after the read with game_rdata=10.
- vga_req=1 continuously, game_valid=1 read: game_ready=0 for 8 cycles, then 1 on the 9th; that cycle's next-edge vga_valid=0 and vga_data unchanged; VGA resumes after.
- Game write (15,2)=01: transfer completes, mem_we stays 0. Game read (2,15): rdata=11. VGA read (15,0): vga_data=11.
- Reset asserted during game read transfer cycle: no game_rvalid; INIT sweep restarts from (0,0).
- Alternating vga_req with game requests: every VGA read returns the memory value at its coordinates 1 cycle later; the tag never misroutes (scoreboard against a memory model).

Source files
------------

// File: rtl/grid_pkg.sv
// Shared types and constants for the snake-grid cell memory arbiter.
package grid_pkg;

    localparam int unsigned GRID_W           = 15;
    localparam int unsigned GRID_H           = 15;
    localparam int unsigned COORD_W          = 4;
    localparam int unsigned DATA_W           = 2;
    localparam int unsigned MAX_WAIT_DEFAULT = 8;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [DATA_W-1:0]  cell_t;

    localparam cell_t CELL_WORLD   = 2'b00;
    localparam cell_t CELL_FOOD    = 2'b01;
    localparam cell_t CELL_SNAKE   = 2'b10;
    localparam cell_t CELL_INVALID = 2'b11;

    // Who owns the read currently in flight through the memory.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_VGA  = 2'b01,
        OWN_GAME = 2'b10
    } owner_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Read-return tag: owner plus a flag that forces CELL_INVALID.
    typedef struct packed {
        owner_e owner;
        logic   oob;
    } rd_tag_t;

    // True when (x, y) addresses a real cell of the grid.
    function automatic logic in_grid(input coord_t x, input coord_t y);
        return (x < COORD_W'(GRID_W)) && (y < COORD_W'(GRID_H));
    endfunction

endpackage

// File: rtl/grid_clear_sweeper.sv
// Walks every grid cell once, x inner / y outer, one cell per enabled cycle.
module grid_clear_sweeper
    import grid_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en_i,
    output coord_t x_o,
    output coord_t y_o,
    output logic   done_o
);

    coord_t x_q, x_d;
    coord_t y_q, y_d;
    logic   last_x_c;
    logic   last_y_c;

    assign last_x_c = (x_q == COORD_W'(GRID_W - 1));
    assign last_y_c = (y_q == COORD_W'(GRID_H - 1));

    // Advance the sweep position; wrap to (0,0) after the last cell.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (en_i) begin
            if (last_x_c) begin
                x_d = '0;
                y_d = last_y_c ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Sweep position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign done_o = en_i && last_x_c && last_y_c;

endmodule

// File: rtl/grid_mem_arbiter.sv
// Single-port owner of the grid memory: clears it, then arbitrates VGA
// pixel fetches (priority) against game-engine requests with a starvation guard.
module grid_mem_arbiter
    import grid_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vga_req,
    input  logic [COORD_W-1:0] vga_x,
    input  logic [COORD_W-1:0] vga_y,
    output logic [DATA_W-1:0]  vga_data,
    output logic               vga_valid,
    input  logic               game_valid,
    output logic               game_ready,
    input  logic               game_we,
    input  logic [COORD_W-1:0] game_x,
    input  logic [COORD_W-1:0] game_y,
    input  logic [DATA_W-1:0]  game_wdata,
    output logic [DATA_W-1:0]  game_rdata,
    output logic               game_rvalid,
    output logic [COORD_W-1:0] mem_x,
    output logic [COORD_W-1:0] mem_y,
    output logic               mem_we,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               init_done
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    state_e            state_q, state_d;
    logic              init_go_q;
    logic              init_done_q, init_done_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    rd_tag_t           tag_q, tag_d;
    cell_t             vga_data_q, vga_data_d;
    cell_t             game_rdata_q, game_rdata_d;
    cell_t             rd_cell_c;
    logic              game_grant_c;

    logic              sweep_en_c;
    coord_t            sweep_x;
    coord_t            sweep_y;
    logic              sweep_done;

    // The sweep starts one cycle after reset release so the port is quiet in reset.
    assign sweep_en_c = (state_q == ST_INIT) && init_go_q;

    grid_clear_sweeper u_sweeper (
        .clk    (clk),
        .rst_n  (rst),
        .en_i   (sweep_en_c),
        .x_o    (sweep_x),
        .y_o    (sweep_y),
        .done_o (sweep_done)
    );

    // Next-state, grant decision, memory port mux and read tagging.
    always_comb begin
        state_d      = state_q;
        init_done_d  = init_done_q;
        wait_cnt_d   = wait_cnt_q;
        tag_d        = '{owner: OWN_NONE, oob: 1'b0};
        game_grant_c = 1'b0;
        mem_x        = '0;
        mem_y        = '0;
        mem_we       = 1'b0;
        mem_wdata    = CELL_WORLD;

        unique case (state_q)
            ST_INIT: begin
                wait_cnt_d = '0;
                if (sweep_en_c) begin
                    mem_x  = sweep_x;
                    mem_y  = sweep_y;
                    mem_we = 1'b1;
                    if (sweep_done) begin
                        state_d     = ST_RUN;
                        init_done_d = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (vga_req && (wait_cnt_q < WAIT_W'(MAX_WAIT))) begin
                    mem_x = vga_x;
                    mem_y = vga_y;
                    tag_d = '{owner: OWN_VGA, oob: !in_grid(vga_x, vga_y)};
                end else if (game_valid) begin
                    game_grant_c = 1'b1;
                    mem_x        = game_x;
                    mem_y        = game_y;
                    mem_wdata    = game_wdata;
                    mem_we       = game_we && in_grid(game_x, game_y);
                    if (!game_we) begin
                        tag_d = '{owner: OWN_GAME, oob: !in_grid(game_x, game_y)};
                    end
                end

                // Count blocked cycles of a pending game request, saturating.
                if (game_valid && !game_grant_c) begin
                    if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else begin
                    wait_cnt_d = '0;
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Route the returning memory word to its owner; holders keep the last value.
    always_comb begin
        rd_cell_c    = tag_q.oob ? CELL_INVALID : mem_rdata;
        vga_data_d   = vga_data_q;
        game_rdata_d = game_rdata_q;
        if (tag_q.owner == OWN_VGA) begin
            vga_data_d = rd_cell_c;
        end
        if (tag_q.owner == OWN_GAME) begin
            game_rdata_d = rd_cell_c;
        end
    end

    // State, counters, tag and read-data holding registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_INIT;
            init_go_q    <= 1'b0;
            init_done_q  <= 1'b0;
            wait_cnt_q   <= '0;
            tag_q        <= '{owner: OWN_NONE, oob: 1'b0};
            vga_data_q   <= CELL_WORLD;
            game_rdata_q <= CELL_WORLD;
        end else begin
            state_q      <= state_d;
            init_go_q    <= 1'b1;
            init_done_q  <= init_done_d;
            wait_cnt_q   <= wait_cnt_d;
            tag_q        <= tag_d;
            vga_data_q   <= vga_data_d;
            game_rdata_q <= game_rdata_d;
        end
    end

    assign game_ready  = game_grant_c;
    assign vga_valid   = (tag_q.owner == OWN_VGA);
    assign vga_data    = vga_data_d;
    assign game_rvalid = (tag_q.owner == OWN_GAME);
    assign game_rdata  = game_rdata_d;
    assign init_done   = init_done_q;

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Randomized bench for grid_mem_arbiter with a grid-level reference model.
module tb_grid_mem_arbiter;

    localparam int MW = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vga_req = 1'b0;
    logic [3:0] vga_x = '0;
    logic [3:0] vga_y = '0;
    logic [1:0] vga_data;
    logic       vga_valid;
    logic       game_valid = 1'b0;
    logic       game_ready;
    logic       game_we = 1'b0;
    logic [3:0] game_x = '0;
    logic [3:0] game_y = '0;
    logic [1:0] game_wdata = '0;
    logic [1:0] game_rdata;
    logic       game_rvalid;
    logic [3:0] mem_x;
    logic [3:0] mem_y;
    logic       mem_we;
    logic [1:0] mem_wdata;
    logic [1:0] mem_rdata = '0;
    logic       init_done;
    logic       scramble = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: expected grid contents and expected read returns.
    logic [1:0] grid [0:15][0:15];
    int         waited;
    bit         pv, pg;
    logic [1:0] pvd, pgd, last_v, last_g;

    // Physical memory behind the port (synchronous read, 1-cycle latency).
    logic [1:0] phys [0:15][0:15];

    always #5 clk = ~clk;

    grid_mem_arbiter #(.MAX_WAIT(MW)) dut (
        .clk         (clk),
        .rst         (rst),
        .vga_req     (vga_req),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_data    (vga_data),
        .vga_valid   (vga_valid),
        .game_valid  (game_valid),
        .game_ready  (game_ready),
        .game_we     (game_we),
        .game_x      (game_x),
        .game_y      (game_y),
        .game_wdata  (game_wdata),
        .game_rdata  (game_rdata),
        .game_rvalid (game_rvalid),
        .mem_x       (mem_x),
        .mem_y       (mem_y),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .init_done   (init_done)
    );

    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++)
                    phys[i][j] <= 2'($urandom_range(1, 3));
        end else begin
            if (mem_we) phys[mem_y][mem_x] <= mem_wdata;
            mem_rdata <= phys[mem_y][mem_x];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic bit in_rng(input logic [3:0] x, input logic [3:0] y);
        return (x < 4'd15) && (y < 4'd15);
    endfunction

    function automatic logic [1:0] cell_at(input logic [3:0] x, input logic [3:0] y);
        return in_rng(x, y) ? grid[y][x] : 2'b11;
    endfunction

    // One RUN cycle: check outputs against the model, then advance the model.
    task automatic run_cycle(output bit xfer);
        bit vwin;
        bit inr;
        @(negedge clk);
        vwin = vga_req && (waited < MW);
        xfer = game_valid && !vwin;
        inr  = in_rng(game_x, game_y);
        check("game_ready", 32'(game_ready), 32'(xfer));
        check("vga_valid", 32'(vga_valid), 32'(pv));
        check("vga_data", 32'(vga_data), 32'(pv ? pvd : last_v));
        check("game_rvalid", 32'(game_rvalid), 32'(pg));
        check("game_rdata", 32'(game_rdata), 32'(pg ? pgd : last_g));
        if (vwin)
            check("mem_port_vga", 32'({mem_we, mem_x, mem_y}), 32'({1'b0, vga_x, vga_y}));
        else if (game_valid) begin
            check("mem_port_game", 32'({mem_we, mem_x, mem_y}), 32'({game_we && inr, game_x, game_y}));
            if (game_we && inr) check("mem_wdata", 32'(mem_wdata), 32'(game_wdata));
        end else
            check("mem_port_idle", 32'({mem_we, mem_x, mem_y}), 32'd0);
        if (pv) last_v = pvd;
        if (pg) last_g = pgd;
        pv = vwin;
        if (vwin) pvd = cell_at(vga_x, vga_y);
        pg = xfer && !game_we;
        if (pg) pgd = cell_at(game_x, game_y);
        if (xfer && game_we && inr) grid[game_y][game_x] = game_wdata;
        if (game_valid && !xfer) waited = (waited < MW) ? waited + 1 : MW;
        else waited = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit xf;
        vga_req = 1'b0;
        game_valid = 1'b0;
        for (int i = 0; i < n; i++) run_cycle(xf);
    endtask

    task automatic vga_read(input logic [3:0] x, input logic [3:0] y);
        bit xf;
        vga_req = 1'b1;
        vga_x = x;
        vga_y = y;
        run_cycle(xf);
        vga_req = 1'b0;
    endtask

    // Issue one game request and hold it until accepted; lat = cycles to accept.
    task automatic game_op(input bit we, input logic [3:0] x, input logic [3:0] y,
                           input logic [1:0] wd, input bit vga_on, output int lat);
        bit xf;
        game_valid = 1'b1;
        game_we = we;
        game_x = x;
        game_y = y;
        game_wdata = wd;
        lat = 0;
        do begin
            vga_req = vga_on;
            vga_x = 4'($urandom % 16);
            vga_y = 4'($urandom % 16);
            run_cycle(xf);
            lat++;
        end while (!xf && lat < 20);
        if (!xf) check("game_accept_timeout", 32'd0, 32'd1);
        game_valid = 1'b0;
        vga_req = 1'b0;
    endtask

    // Follow the clearing sweep after reset release and reset the model.
    task automatic do_init();
        int guard;
        int nz;
        guard = 0;
        @(negedge clk);
        while (!mem_we && guard < 4) begin
            check("init_wait_quiet", 32'({vga_valid, game_ready, game_rvalid, init_done}), 32'd0);
            @(negedge clk);
            guard++;
        end
        for (int y = 0; y < 15; y++) begin
            for (int x = 0; x < 15; x++) begin
                if (x != 0 || y != 0) @(negedge clk);
                check("init_cell", 32'({mem_we, mem_wdata, mem_x, mem_y}),
                      32'({1'b1, 2'b00, 4'(x), 4'(y)}));
                check("init_quiet", 32'({vga_valid, game_ready, game_rvalid, init_done}), 32'd0);
                vga_req = 1'($urandom % 2);
                vga_x = 4'($urandom % 16);
                vga_y = 4'($urandom % 16);
            end
        end
        vga_req = 1'b0;
        @(negedge clk);
        check("init_done", 32'(init_done), 32'd1);
        check("init_after_quiet", 32'({vga_valid, game_ready, mem_we}), 32'd0);
        nz = 0;
        for (int i = 0; i < 15; i++)
            for (int j = 0; j < 15; j++)
                if (phys[i][j] != 2'b00) nz++;
        check("grid_cleared", 32'(nz), 32'd0);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                grid[i][j] = 2'b00;
        pv = 0; pg = 0; pvd = '0; pgd = '0; last_v = '0; last_g = '0; waited = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        bit xf;

        scramble = 1'b1;
        @(posedge clk);
        #1;
        scramble = 1'b0;
        @(negedge clk);
        check("rst_outputs", 32'({vga_valid, vga_data, game_ready, game_rvalid, game_rdata, init_done}), 32'd0);
        check("rst_mem_port", 32'({mem_we, mem_wdata, mem_x, mem_y}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        do_init();

        // Write then immediately read back the same cell.
        game_op(1'b1, 4'd3, 4'd4, 2'b10, 1'b0, lat);
        check("wr_latency", 32'(lat), 32'd1);
        game_op(1'b0, 4'd3, 4'd4, 2'b00, 1'b0, lat);
        check("rd_latency", 32'(lat), 32'd1);
        idle(1);
        check("rd_3_4_hold", 32'(game_rdata), 32'd2);

        // Starvation guard: VGA asks every cycle, game must get in on cycle 9.
        vga_read(4'd3, 4'd4);
        game_op(1'b0, 4'd3, 4'd4, 2'b00, 1'b1, lat);
        check("preempt_latency", 32'(lat), 32'd9);
        vga_req = 1'b1;
        vga_x = 4'd0;
        vga_y = 4'd0;
        run_cycle(xf);
        run_cycle(xf);
        vga_req = 1'b0;
        idle(1);
        check("vga_resumed", 32'(vga_data), 32'd0);

        // Out-of-range coordinates from both requesters.
        game_op(1'b1, 4'd15, 4'd2, 2'b01, 1'b0, lat);
        check("oob_wr_latency", 32'(lat), 32'd1);
        game_op(1'b0, 4'd2, 4'd15, 2'b00, 1'b0, lat);
        idle(1);
        check("oob_game_rd", 32'(game_rdata), 32'd3);
        vga_read(4'd15, 4'd0);
        idle(1);
        check("oob_vga_rd", 32'(vga_data), 32'd3);

        // Random mix of VGA fetches and game traffic.
        for (int c = 0; c < 700; c++) begin
            if (!game_valid && ($urandom % 3 == 0)) begin
                game_valid = 1'b1;
                game_we = 1'($urandom % 2);
                game_x = ($urandom % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom % 16);
                game_y = ($urandom % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom % 16);
                game_wdata = 2'($urandom % 4);
            end
            vga_req = ($urandom % 4) != 0;
            vga_x = ($urandom % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom % 16);
            vga_y = ($urandom % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom % 16);
            run_cycle(xf);
            if (xf) game_valid = 1'b0;
        end
        vga_req = 1'b0;
        for (int k = 0; k < 12 && game_valid; k++) begin
            run_cycle(xf);
            if (xf) game_valid = 1'b0;
        end
        check("drain_done", 32'(game_valid), 32'd0);
        idle(2);

        // Reset during a game read transfer: no return, sweep restarts.
        vga_req = 1'b0;
        game_valid = 1'b1;
        game_we = 1'b0;
        game_x = 4'd5;
        game_y = 4'd5;
        @(negedge clk);
        check("rst_xfer_ready", 32'(game_ready), 32'd1);
        rst = 1'b0;
        #1;
        check("rst_async_ready", 32'(game_ready), 32'd0);
        game_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_no_rvalid", 32'(game_rvalid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_rel_quiet", 32'({game_rvalid, init_done, mem_we}), 32'd0);
        do_init();

        game_op(1'b1, 4'd7, 4'd7, 2'b01, 1'b0, lat);
        game_op(1'b0, 4'd7, 4'd7, 2'b00, 1'b0, lat);
        idle(1);
        check("post_reinit_rd", 32'(game_rdata), 32'd1);
        vga_read(4'd7, 4'd7);
        idle(1);
        check("post_reinit_vga", 32'(vga_data), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
